ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends command bytes such as LED set (0xED) and enable scanning (0xF4) to the attached keyboard. The block sits inside `peripherals`, next to the existing PS/2 receiver. It drives the shared PS/2 clock and data lines as open-drain pull-downs, and it raises `busy` so the receiver ignores line activity while a host transfer is in flight.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000: cycles `ps2_clk` is held low before the start bit (100 µs at the 50 MHz `dclk`).
- TIMEOUT_CYCLES, 750000: watchdog limit of 15 ms, measured from the end of inhibit to the return to idle.

Ports:
- clk  in  1  system clock, the 50 MHz `dclk`.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  request; the byte is accepted on a cycle with `tx_valid && tx_ready`.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: transfer acknowledged by the device.
- err  out  1  one-cycle pulse: NACK or timeout.
- ps2_clk_i  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data_i  in  1  raw PS/2 data pin (asynchronous).
- ps2_clk_oe  out  1  1 pulls the clock line low; 0 releases it.
- ps2_data_oe  out  1  1 pulls the data line low; 0 releases it.

## Operation
- Both pin inputs pass through a 2-FF synchronizer.
- A falling edge (`fe`) is detected when the previous synchronized clock sample is 1 and the current one is 0.
- On acceptance, the byte is latched and the odd parity bit `par = ~^tx_data` is computed.
- State machine:
  - IDLE: both lines released. On accept, go to INHIBIT.
  - INHIBIT: `ps2_clk_oe=1`, `ps2_data_oe=0` for INHIBIT_CYCLES cycles, then go to START.
  - START: `ps2_clk_oe=1`, `ps2_data_oe=1` for exactly 1 cycle, then go to SHIFT with `ps2_clk_oe=0`. The data line stays low; this is the start bit.
  - SHIFT: a bit counter is reset to 0 on entry and increments on each `fe`.
    - `fe` 1–8: drive data bits D0..D7, LSB first, with `ps2_data_oe = ~bit`.
    - `fe` 9: drive parity, with `ps2_data_oe = ~par`.
    - `fe` 10: release data (stop bit = 1) and go to ACK.
  - ACK: on the next `fe`, sample synchronized data. If 0, set the ack flag; if 1, set the nack flag. Then go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1.
    - If ack, pulse `done`.
    - If nack, pulse `err`.
    - Go to IDLE.
- In all states other than IDLE, `tx_valid` is ignored.

## Timing
- Reset values: state IDLE, `ps2_clk_oe=0`, `ps2_data_oe=0`, `tx_ready=1`, `busy=0`, `done=0`, `err=0`. Reset acts asynchronously, so both lines are released immediately even mid-transfer.
- All outputs are registered except `tx_ready` and `busy`, which decode the registered state.
- Accept at clock edge N: `ps2_clk_oe` rises at N+1.
- `ps2_data_oe` asserts INHIBIT_CYCLES cycles later.
- `ps2_clk_oe` deasserts 1 cycle after `ps2_data_oe` asserts.
- Latency from a pin falling edge to a data change is 3 cycles (2 for the synchronizer, 1 for the register). This is far below the 30 µs low phase of the PS/2 clock.
- `done`/`err` pulse high for 1 cycle in the cycle IDLE is re-entered. `tx_ready` is 1 in that same cycle, so back-to-back transfers are legal.
- `done` and `err` are never both high.

## Configuration
- Macro `PS2_HOST_TX_TIMEOUT_EN`, defined:
  - A watchdog counter clears on entry to START and counts every cycle through SHIFT/ACK/WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES, it releases both lines, pulses `err` and returns to IDLE the next cycle.
  - A timeout takes priority over a simultaneous `fe`.
- Macro undefined: there is no watchdog, and the block waits indefinitely for device clocks.

## Test plan
- Send 0xF4 with a device model acknowledging: bits 0,0,1,0,1,1,1,1, parity 0, stop 1 seen on data at device rising edges; data low at `fe` 11 → `done`=1 for one cycle, `err`=0.
- Send 0xED: parity bit driven as 1 (six ones in the data) → `done`; check INHIBIT length is exactly 5000 cycles of `ps2_clk_oe=1` before `ps2_data_oe` rises.
- NACK: device leaves data high at `fe` 11 → `err`=1, `done`=0, lines released, `tx_ready`=1 after lines idle.
- Timeout (macro defined, TIMEOUT_CYCLES=1000 in the bench): device never clocks → `err` pulses 1000 cycles after START, both OE low, state IDLE.
- Reset: assert `rst` low after `fe` 5 → `ps2_clk_oe`/`ps2_data_oe` go to 0 without a clock edge. After release, a new 0xF4 transfer completes with `done`.
- Back-to-back: hold `tx_valid` with 0xED then 0xF4 → second accept occurs in the `done` cycle; both bytes are observed correctly by the device model.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter driving open-drain clock/data pull-downs.
// Defining PS2_HOST_TX_TIMEOUT_EN adds a watchdog that aborts a stalled transfer with err.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);
   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE} state_e;
   state_e        state_q;
   logic [1:0]    clk_sync_q, data_sync_q;
   logic          clk_prev_q;
   logic [IW-1:0] inh_q;
   logic [3:0]    bit_q;
   logic [7:0]    byte_q;
   logic          par_q, ack_q, clk_oe_q, data_oe_q, done_q, err_q;
   logic          fe, line_idle, to_hit;
   assign fe          = clk_prev_q & ~clk_sync_q[1];
   assign line_idle   = clk_sync_q[1] & data_sync_q[1];
   assign tx_ready    = state_q == IDLE;
   assign busy        = ~tx_ready;
   assign done        = done_q;
   assign err         = err_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
`ifdef PS2_HOST_TX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wd_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wd_q <= '0;
      else wd_q <= (state_q == IDLE || state_q == INHIBIT) ? '0 : wd_q + 1'b1;
   end
   assign to_hit = (state_q == SHIFT || state_q == ACK || state_q == WAIT_IDLE) &&
                   wd_q == TW'(TIMEOUT_CYCLES - 1);
`else
   // watchdog compiled out: never fires
   assign to_hit = TIMEOUT_CYCLES < 0;
`endif
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
         inh_q       <= '0;
         bit_q       <= '0;
         byte_q      <= '0;
         par_q       <= 1'b0;
         ack_q       <= 1'b0;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
         clk_prev_q  <= clk_sync_q[1];
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         if (to_hit) begin
            state_q   <= IDLE;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
         end else begin
            case (state_q)
               IDLE: if (tx_valid) begin
                  byte_q   <= tx_data;
                  par_q    <= ~^tx_data;
                  inh_q    <= '0;
                  clk_oe_q <= 1'b1;
                  state_q  <= INHIBIT;
               end
               INHIBIT: begin
                  inh_q <= inh_q + 1'b1;
                  if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
                     data_oe_q <= 1'b1;
                     state_q   <= START;
                  end
               end
               START: begin
                  clk_oe_q <= 1'b0;
                  bit_q    <= '0;
                  state_q  <= SHIFT;
               end
               // counts 0-7 data, 8 parity, 9 releases data for the stop bit
               SHIFT: if (fe) begin
                  bit_q     <= bit_q + 1'b1;
                  data_oe_q <= bit_q[3] ? (~bit_q[0] & ~par_q) : ~byte_q[bit_q[2:0]];
                  if (bit_q == 4'd9) state_q <= ACK;
               end
               ACK: if (fe) begin
                  ack_q   <= ~data_sync_q[1];
                  state_q <= WAIT_IDLE;
               end
               WAIT_IDLE: if (line_idle) begin
                  done_q  <= ack_q;
                  err_q   <= ~ack_q;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a PS/2 device model on open-drain lines.
module tb_ps2_host_tx;
   localparam int IC = 5000;
   localparam int TC = 1000;
   localparam int H  = 15;
   typedef struct packed {logic [9:0] frame; logic ack; logic framed;} exp_t;
   logic       clk = 1'b0, rst = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe;
   logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
   wire        ps2_clk_i  = !(ps2_clk_oe || dev_clk_low);
   wire        ps2_data_i = !(ps2_data_oe || dev_data_low);
   exp_t       exp_q[$];
   logic [9:0] frame_q[$];
   exp_t       mon_e;
   int         errors = 0, checks = 0;

   always #5 clk = ~clk;

   ps2_host_tx #(.INHIBIT_CYCLES(IC), .TIMEOUT_CYCLES(TC)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .done(done), .err(err),
      .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // monitor: every done/err pulse consumes one expected result
   always @(negedge clk) begin
      if (rst && (done || err)) begin
         chk("done_err_exclusive", 32'(done && err), 0);
         chk("ready_in_pulse", 32'(tx_ready), 1);
         if (exp_q.size() == 0) chk("unexpected_pulse", 0, 1);
         else begin
            mon_e = exp_q.pop_front();
            chk("result_done_err", {done, err}, mon_e.ack ? 2'b10 : 2'b01);
            if (err) chk("oe_released_on_err", {ps2_clk_oe, ps2_data_oe}, 0);
            if (mon_e.framed) begin
               if (frame_q.size() == 0) chk("frame_missing", 0, 1);
               else chk("device_frame", frame_q.pop_front(), mon_e.frame);
            end
         end
      end
   end

   task automatic device(input logic ack, input int abort_at);
      int n;
      logic [9:0] f;
      n = 0;
      f = '0;
      while (!(ps2_data_oe && !ps2_clk_oe) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) begin
         chk("request_to_send_seen", 0, 1);
         return;
      end
      repeat (H) @(negedge clk);
      for (int k = 1; k <= 11; k++) begin
         dev_clk_low = 1'b1;
         repeat (H) @(negedge clk);
         if (k == abort_at) begin
            chk("pre_reset_data_oe", 32'(ps2_data_oe), 1);
            rst = 1'b0;
            #1;
            chk("async_reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
            chk("async_reset_busy", 32'(busy), 0);
            dev_clk_low = 1'b0;
            return;
         end
         if (k <= 10) f[k-1] = ps2_data_i;
         if (k == 10) frame_q.push_back(f);
         dev_clk_low = 1'b0;
         repeat (H) @(negedge clk);
         if (k == 10) dev_data_low = ack;
      end
      dev_data_low = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic [9:0] fr, input logic ack, input logic framed);
      int n;
      n = 0;
      while (!tx_ready && n < 20000) begin
         @(negedge clk);
         n++;
      end
      exp_q.push_back({fr, ack, framed});
      tx_data = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("clk_oe_after_accept", 32'(ps2_clk_oe), 1);
      chk("busy_after_accept", 32'(busy), 1);
   endtask

   task automatic measure_inhibit();
      int n;
      n = 0;
      while (!ps2_data_oe && n < IC + 100) begin
         n++;
         @(negedge clk);
      end
      chk("inhibit_length", n, IC);
      chk("start_clk_oe", 32'(ps2_clk_oe), 1);
      @(negedge clk);
      chk("shift_entry_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 40000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40000) chk("drain_timeout", 0, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_clk_oe", 32'(ps2_clk_oe), 0);
      chk("reset_data_oe", 32'(ps2_data_oe), 0);
      chk("reset_tx_ready", 32'(tx_ready), 1);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done_err", {done, err}, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      // 0xF4: data bits LSB first 0,0,1,0,1,1,1,1, parity 0, stop 1
      fork
         send(8'hF4, 10'b1_0_11110100, 1'b1, 1'b1);
         device(1'b1, 0);
      join
      wait_drain();
      // 0xED: six ones, parity 1
      fork
         begin
            send(8'hED, 10'b1_1_11101101, 1'b1, 1'b1);
            measure_inhibit();
         end
         device(1'b1, 0);
      join
      wait_drain();
      fork
         send(8'hF4, 10'b1_0_11110100, 1'b0, 1'b1);
         device(1'b0, 0);
      join
      wait_drain();
      chk("nack_ready", 32'(tx_ready), 1);
      chk("nack_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
      // reset after the fifth falling edge while D4=0 is being driven
      fork
         send(8'h00, 10'b1_1_00000000, 1'b1, 1'b1);
         device(1'b1, 5);
      join
      exp_q.delete();
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      fork
         send(8'hF4, 10'b1_0_11110100, 1'b1, 1'b1);
         device(1'b1, 0);
      join
      wait_drain();
      // back-to-back: second accept lands in the done cycle
      exp_q.push_back({10'b1_1_11101101, 1'b1, 1'b1});
      exp_q.push_back({10'b1_0_11110100, 1'b1, 1'b1});
      fork
         begin
            int n;
            n = 0;
            tx_data = 8'hED;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_data = 8'hF4;
            while (!tx_ready && n < 20000) begin
               @(negedge clk);
               n++;
            end
            chk("b2b_accept_in_done", 32'(done), 1);
            @(negedge clk);
            tx_valid = 1'b0;
            chk("b2b_second_accepted", 32'(busy), 1);
         end
         begin
            device(1'b1, 0);
            device(1'b1, 0);
         end
      join
      wait_drain();
`ifdef PS2_HOST_TX_TIMEOUT_EN
      fork
         send(8'hF4, 10'b0, 1'b0, 1'b0);
         begin
            int n;
            n = 0;
            while (!ps2_data_oe && n < IC + 100) begin
               @(negedge clk);
               n++;
            end
            n = 0;
            while (!err && n < TC + 100) begin
               @(negedge clk);
               n++;
            end
            chk("timeout_cycles", n, TC);
            @(negedge clk);
            chk("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
            chk("timeout_idle", 32'(tx_ready), 1);
         end
      join
      wait_drain();
`endif
      chk("pending_results", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
